// File: rtl/tri_raster_ctrl.sv
// Triangle raster sequencer: scans a clamped bounding box, pairs in-order tester results
// with issued coordinates, and streams inside pixels. Optional macro: DEGEN_SKIP_EN.
module tri_raster_ctrl #(
    parameter int CW    = 9,
    parameter int MAX_X = 319,
    parameter int MAX_Y = 239,
    parameter int DEPTH = 4
) (
    input  logic            CLOCK_50,
    input  logic            RESET,
    input  logic            start,
    input  logic [CW-1:0]   ax,
    input  logic [CW-1:0]   ay,
    input  logic [CW-1:0]   bx,
    input  logic [CW-1:0]   by,
    input  logic [CW-1:0]   cx,
    input  logic [CW-1:0]   cy,
    output logic            busy,
    output logic            done,
    output logic            test_valid,
    input  logic            test_ready,
    output logic [CW-1:0]   test_px,
    output logic [CW-1:0]   test_py,
    input  logic            res_valid,
    input  logic            res_inside,
    output logic            pix_valid,
    input  logic            pix_ready,
    output logic [CW-1:0]   pix_x,
    output logic [CW-1:0]   pix_y,
    output logic [2*CW-1:0] pix_count,
    output logic            err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] LIM_X   = CW'(MAX_X);
    localparam logic [CW-1:0] LIM_Y   = CW'(MAX_Y);
    localparam logic [NW:0]   DEPTH_V = DEPTH[NW:0];

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t state, state_n;

    logic [CW-1:0]   va_x, va_y, vb_x, vb_y, vc_x, vc_y;
    logic [CW-1:0]   xmin, xmax, ymin, ymax;
    logic [CW-1:0]   px, py;
    logic [CW-1:0]   bb_xmin, bb_xmax, bb_ymin, bb_ymax;

    logic [2*CW-1:0] mem_c [DEPTH];
    logic [2*CW-1:0] mem_p [DEPTH];
    logic [AW-1:0]   wp_c, rp_c, wp_p, rp_p;
    logic [NW-1:0]   cnt_c, cnt_p;
    logic [2*CW-1:0] p_head;

    logic test_xfer, c_pop, p_push, p_pop, scan_last, credit_ok;

    function automatic logic [CW-1:0] min3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] max3(input logic [CW-1:0] a, b, c);
        logic [CW-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [CW-1:0] clamp(input logic [CW-1:0] v, lim);
        return (v > lim) ? lim : v;
    endfunction

    assign bb_xmin = clamp(min3(va_x, vb_x, vc_x), LIM_X);
    assign bb_xmax = clamp(max3(va_x, vb_x, vc_x), LIM_X);
    assign bb_ymin = clamp(min3(va_y, vb_y, vc_y), LIM_Y);
    assign bb_ymax = clamp(max3(va_y, vb_y, vc_y), LIM_Y);

`ifdef DEGEN_SKIP_EN
    localparam int AR = 2*CW + 2;
    logic signed [AR-1:0] sxa, sya, sxb, syb, sxc, syc, area;
    assign sxa  = $signed(AR'(va_x));
    assign sya  = $signed(AR'(va_y));
    assign sxb  = $signed(AR'(vb_x));
    assign syb  = $signed(AR'(vb_y));
    assign sxc  = $signed(AR'(vc_x));
    assign syc  = $signed(AR'(vc_y));
    assign area = sxa * (syb - syc) + sxb * (syc - sya) + sxc * (sya - syb);
`endif

    // Credit covers both unresolved requests and buffered pixels, so the pixel FIFO cannot overflow.
    assign credit_ok = ({1'b0, cnt_c} + {1'b0, cnt_p}) < DEPTH_V;
    assign test_xfer = test_valid & test_ready;
    assign c_pop     = res_valid & (cnt_c != '0);
    assign p_push    = c_pop & res_inside;
    assign pix_valid = (cnt_p != '0);
    assign p_pop     = pix_valid & pix_ready;
    assign scan_last = (px == xmax) && (py == ymax);

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n    = state;
        test_valid = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  if (start) state_n = S_SETUP;
`ifdef DEGEN_SKIP_EN
            S_SETUP: state_n = (area == '0) ? S_DONE : S_SCAN;
`else
            S_SETUP: state_n = S_SCAN;
`endif
            S_SCAN: begin
                test_valid = credit_ok;
                if (credit_ok && test_ready && scan_last) state_n = S_DRAIN;
            end
            S_DRAIN: if (cnt_c == '0 && cnt_p == '0) state_n = S_DONE;
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= S_IDLE;
            {va_x, va_y, vb_x, vb_y, vc_x, vc_y} <= '0;
            {xmin, xmax, ymin, ymax} <= '0;
            px        <= '0;
            py        <= '0;
            wp_c      <= '0;
            rp_c      <= '0;
            wp_p      <= '0;
            rp_p      <= '0;
            cnt_c     <= '0;
            cnt_p     <= '0;
            pix_count <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && start) begin
                va_x <= ax; va_y <= ay;
                vb_x <= bx; vb_y <= by;
                vc_x <= cx; vc_y <= cy;
                pix_count <= '0;
            end else if (p_pop) begin
                pix_count <= pix_count + (2*CW)'(1);
            end

            if (state == S_SETUP) begin
                xmin <= bb_xmin;
                xmax <= bb_xmax;
                ymin <= bb_ymin;
                ymax <= bb_ymax;
                px   <= bb_xmin;
                py   <= bb_ymin;
            end else if (test_xfer) begin
                if (px == xmax) begin
                    px <= xmin;
                    py <= py + CW'(1);
                end else begin
                    px <= px + CW'(1);
                end
            end

            if (test_xfer) wp_c <= wp_c + AW'(1);
            if (c_pop)     rp_c <= rp_c + AW'(1);
            if (p_push)    wp_p <= wp_p + AW'(1);
            if (p_pop)     rp_p <= rp_p + AW'(1);
            cnt_c <= cnt_c + NW'(test_xfer) - NW'(c_pop);
            cnt_p <= cnt_p + NW'(p_push) - NW'(p_pop);

            if (res_valid && cnt_c == '0) err <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy counters alone decide what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (test_xfer) mem_c[wp_c] <= {px, py};
        if (p_push)    mem_p[wp_p] <= mem_c[rp_c];
    end

    assign p_head  = mem_p[rp_p];
    assign busy    = (state != S_IDLE);
    assign test_px = px;
    assign test_py = py;
    assign pix_x   = pix_valid ? p_head[2*CW-1:CW] : '0;
    assign pix_y   = pix_valid ? p_head[CW-1:0]    : '0;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Self-checking bench for tri_raster_ctrl: behavioural bbox/edge-function model,
// latency-3 in-order tester model, per-cycle compare of requests, pixels and credit.
module tb_tri_raster_ctrl;

    localparam int CW    = 9;
    localparam int MAX_X = 319;
    localparam int MAX_Y = 239;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int BOUND = 20000;

    logic            CLOCK_50 = 1'b0;
    logic            RESET    = 1'b1;
    logic            start    = 1'b0;
    logic [CW-1:0]   ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
    logic            busy, done, test_valid;
    logic            test_ready = 1'b0;
    logic [CW-1:0]   test_px, test_py;
    logic            res_valid = 1'b0, res_inside = 1'b0;
    logic            pix_valid;
    logic            pix_ready = 1'b0;
    logic [CW-1:0]   pix_x, pix_y;
    logic [2*CW-1:0] pix_count;
    logic            err;

    tri_raster_ctrl #(.CW(CW), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .DEPTH(DEPTH)) dut (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .start(start),
        .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
        .busy(busy), .done(done),
        .test_valid(test_valid), .test_ready(test_ready),
        .test_px(test_px), .test_py(test_py),
        .res_valid(res_valid), .res_inside(res_inside),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y),
        .pix_count(pix_count), .err(err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {int x; int y;} pt_t;
    typedef struct {int due; bit ins;} res_t;

    pt_t  exp_req[$];
    pt_t  exp_pix[$];
    res_t pend[$];

    int tests = 0, fails = 0, cyc = 0;
    int req_idx = 0, pix_idx = 0, out_cnt = 0, q_cnt = 0, done_cnt = 0;
    bit mon_en = 0, rand_ready = 0, pix_hold = 0, stray_res = 0, prev_stall = 0;
    logic [2*CW-1:0] prev_xy = '0;
    int tax, tay, tbx, tby, tcx, tcy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] xy(input int x, input int y);
        return 64'(x * (1 << CW) + y);
    endfunction

    function automatic bit inside_tri(input int px, input int py);
        int e0, e1, e2;
        e0 = (tbx - tax) * (py - tay) - (tby - tay) * (px - tax);
        e1 = (tcx - tbx) * (py - tby) - (tcy - tby) * (px - tbx);
        e2 = (tax - tcx) * (py - tcy) - (tay - tcy) * (px - tcx);
        return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
    endfunction

    function automatic int lim(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Expected request order and inside-pixel stream for the current triangle.
    task automatic build_model();
        int x0, x1, y0, y1;
        x0 = lim((tax < tbx ? (tax < tcx ? tax : tcx) : (tbx < tcx ? tbx : tcx)), MAX_X);
        x1 = lim((tax > tbx ? (tax > tcx ? tax : tcx) : (tbx > tcx ? tbx : tcx)), MAX_X);
        y0 = lim((tay < tby ? (tay < tcy ? tay : tcy) : (tby < tcy ? tby : tcy)), MAX_Y);
        y1 = lim((tay > tby ? (tay > tcy ? tay : tcy) : (tby > tcy ? tby : tcy)), MAX_Y);
        exp_req.delete();
        exp_pix.delete();
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                exp_req.push_back('{x: x, y: y});
                if (inside_tri(x, y)) exp_pix.push_back('{x: x, y: y});
            end
`ifdef DEGEN_SKIP_EN
        if (tax * (tby - tcy) + tbx * (tcy - tay) + tcx * (tay - tby) == 0) begin
            exp_req.delete();
            exp_pix.delete();
        end
`endif
    endtask

    // Tester model, input driver and per-cycle compare, all at the falling edge.
    always @(negedge CLOCK_50) begin
        cyc++;
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid", 64'(test_valid), 64'(1));
                check("stall_xy", 64'({test_px, test_py}), 64'(prev_xy));
            end
            check("credit_bound", 64'(out_cnt + q_cnt <= DEPTH), 64'(1));
            if (test_valid) check("credit_valid", 64'(out_cnt + q_cnt < DEPTH), 64'(1));
        end
        test_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_ready  = !pix_hold;
        res_valid  = 1'b0;
        res_inside = 1'b0;
        if (stray_res) begin
            res_valid = 1'b1;
            stray_res = 1'b0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            res_valid  = 1'b1;
            res_inside = pend[0].ins;
            void'(pend.pop_front());
        end
        if (mon_en) begin
            if (test_valid && test_ready) begin
                check("req_range", 64'(test_px <= MAX_X && test_py <= MAX_Y), 64'(1));
                if (req_idx < exp_req.size())
                    check("req_xy", 64'({test_px, test_py}), xy(exp_req[req_idx].x, exp_req[req_idx].y));
                else
                    check("req_extra", 64'(req_idx), 64'(exp_req.size()));
                pend.push_back('{due: cyc + LAT, ins: inside_tri(int'(test_px), int'(test_py))});
                req_idx++;
                out_cnt++;
            end
            if (res_valid && out_cnt > 0) begin
                out_cnt--;
                if (res_inside) q_cnt++;
            end
            if (pix_valid && pix_ready) begin
                if (pix_idx < exp_pix.size())
                    check("pix_xy", 64'({pix_x, pix_y}), xy(exp_pix[pix_idx].x, exp_pix[pix_idx].y));
                else
                    check("pix_extra", 64'(pix_idx), 64'(exp_pix.size()));
                check("pix_count_run", 64'(pix_count), 64'(pix_idx));
                pix_idx++;
                q_cnt--;
            end
            if (done) done_cnt++;
            prev_stall = test_valid && !test_ready;
            prev_xy    = {test_px, test_py};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic reset_checks(input string tag);
        check({tag, "_busy"},  64'(busy), 64'(0));
        check({tag, "_done"},  64'(done), 64'(0));
        check({tag, "_tv"},    64'(test_valid), 64'(0));
        check({tag, "_pv"},    64'(pix_valid), 64'(0));
        check({tag, "_err"},   64'(err), 64'(0));
        check({tag, "_cnt"},   64'(pix_count), 64'(0));
        check({tag, "_txy"},   64'({test_px, test_py}), 64'(0));
        check({tag, "_pxy"},   64'({pix_x, pix_y}), 64'(0));
    endtask

    task automatic run_tri(input int a_x, a_y, b_x, b_y, c_x, c_y,
                           input bit rr, input bit stall_mid, input int reset_at);
        int guard;
        tax = a_x; tay = a_y; tbx = b_x; tby = b_y; tcx = c_x; tcy = c_y;
        build_model();
        req_idx = 0; pix_idx = 0; out_cnt = 0; q_cnt = 0; done_cnt = 0;
        pend.delete();
        rand_ready = rr;
        pix_hold   = 1'b0;
        @(negedge CLOCK_50);
        ax = CW'(a_x); ay = CW'(a_y); bx = CW'(b_x); by = CW'(b_y); cx = CW'(c_x); cy = CW'(c_y);
        start  = 1'b1;
        mon_en = 1'b1;
        @(negedge CLOCK_50);
        start = 1'b0;
        check("setup_busy", 64'(busy), 64'(1));
        check("setup_no_req", 64'(test_valid), 64'(0));
        @(negedge CLOCK_50);
        if (exp_req.size() == 0) check("degen_done", 64'(done), 64'(1));
        else                     check("first_req", 64'(test_valid), 64'(1));

        if (stall_mid) begin
            guard = 0;
            while (req_idx < 30 && guard < BOUND) begin @(negedge CLOCK_50); guard++; end
            pix_hold = 1'b1;
            repeat (50) @(negedge CLOCK_50);
            check("stall_no_req", 64'(test_valid), 64'(0));
            check("stall_pix_valid", 64'(pix_valid), 64'(1));
            check("stall_q_full", 64'(q_cnt), 64'(DEPTH));
            pix_hold = 1'b0;
        end

        if (reset_at > 0) begin
            guard = 0;
            while (req_idx < reset_at && guard < BOUND) begin @(negedge CLOCK_50); guard++; end
            check("reset_point", 64'(req_idx >= reset_at), 64'(1));
            mon_en = 1'b0;
            RESET  = 1'b1;
            pend.delete();
            @(negedge CLOCK_50);
            reset_checks("midrst");
            RESET     = 1'b0;
            stray_res = 1'b1;
            repeat (3) @(negedge CLOCK_50);
            check("stray_err", 64'(err), 64'(1));
            return;
        end

        guard = 0;
        while (done_cnt == 0 && guard < BOUND) begin @(negedge CLOCK_50); guard++; end
        check("done_seen", 64'(done_cnt > 0), 64'(1));
        repeat (4) @(negedge CLOCK_50);
        check("done_once", 64'(done_cnt), 64'(1));
        check("req_total", 64'(req_idx), 64'(exp_req.size()));
        check("pix_total", 64'(pix_idx), 64'(exp_pix.size()));
        check("pix_count_final", 64'(pix_count), 64'(exp_pix.size()));
        check("idle_busy", 64'(busy), 64'(0));
        check("drained", 64'(q_cnt + out_cnt), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset_checks("rst");
        RESET = 1'b0;

        // Case 1 plus literal pins on the model.
        run_tri(12, 5, 5, 16, 2, 2, 1'b0, 1'b0, 0);
        check("model_req_n", 64'(exp_req.size()), 64'(165));
        check("model_first", xy(exp_req[0].x, exp_req[0].y), xy(2, 2));
        check("model_last", xy(exp_req[164].x, exp_req[164].y), xy(12, 16));
        check("model_in_vertex", 64'(inside_tri(2, 2)), 64'(1));
        check("model_out_corner", 64'(inside_tri(12, 16)), 64'(0));
        check("err_clean", 64'(err), 64'(0));

        // Case 2: downstream stall mid-scan.
        run_tri(12, 5, 5, 16, 2, 2, 1'b0, 1'b1, 0);
        // Case 3: random test_ready.
        run_tri(12, 5, 5, 16, 2, 2, 1'b1, 1'b0, 0);

        // Case 4: clamped bounding box.
        run_tri(400, 10, 300, 250, 310, 20, 1'b0, 1'b0, 0);
        check("clamp_req_n", 64'(exp_req.size()), 64'(4600));
        check("clamp_first", xy(exp_req[0].x, exp_req[0].y), xy(300, 10));
        check("clamp_last", xy(exp_req[4599].x, exp_req[4599].y), xy(319, 239));

        // Case 5: degenerate triangle.
        run_tri(0, 0, 5, 5, 10, 10, 1'b0, 1'b0, 0);
`ifdef DEGEN_SKIP_EN
        check("degen_req_n", 64'(exp_req.size()), 64'(0));
`else
        check("degen_req_n", 64'(exp_req.size()), 64'(121));
`endif

        // Case 6: reset at request 40, then a clean rerun of case 1.
        run_tri(12, 5, 5, 16, 2, 2, 1'b0, 1'b0, 40);
        run_tri(12, 5, 5, 16, 2, 2, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
